// File: rtl/fir_hls_div_pkg.sv
// Shared types and constants for the sequential signed divider: FSM states,
// default operand widths, quotient saturation limits and bit-counter width.
package fir_hls_div_pkg;

  localparam int DIVIDEND_WIDTH_DEF = 31;
  localparam int DIVISOR_WIDTH_DEF  = 15;
  localparam int QUOTIENT_WIDTH_DEF = 16;

  localparam logic [QUOTIENT_WIDTH_DEF-1:0] QMAX = 16'h7fff;
  localparam logic [QUOTIENT_WIDTH_DEF-1:0] QMIN = 16'h8000;

  // Counter must hold DIVIDEND_WIDTH itself, hence the +1.
  localparam int CNT_W = $clog2(DIVIDEND_WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/fir_hls_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference when it is non-negative.
module fir_hls_div_step #(
  parameter int DSW = 15
) (
  input  logic [DSW:0]   rem_in,
  input  logic           bit_in,
  input  logic [DSW-1:0] dvs,
  output logic [DSW:0]   rem_out,
  output logic           q_bit
);

  logic [DSW+1:0] shifted;
  logic [DSW+1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, dvs};
    q_bit   = ~diff[DSW+1];
    rem_out = q_bit ? diff[DSW:0] : shifted[DSW:0];
  end

endmodule

// File: rtl/fir_hls_sdiv_31s_15s_seq.sv
// Sequential signed restoring divider (31s / 15s -> saturated 16s quotient),
// one quotient bit per cycle, valid/ready on both sides, one division in flight.
module fir_hls_sdiv_31s_15s_seq
  import fir_hls_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
  parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF,
  parameter int QUOTIENT_WIDTH = QUOTIENT_WIDTH_DEF
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int DDW = DIVIDEND_WIDTH;
  localparam int DSW = DIVISOR_WIDTH;
  localparam int QW  = QUOTIENT_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.

  localparam logic [DDW-1:0] POS_LIM = DDW'(QMAX);
  localparam logic [DDW-1:0] NEG_LIM = DDW'(QMAX) + DDW'(1);

  div_state_e state, state_next;

  logic [DDW-1:0]   dvd;
  logic [DSW:0]     prem;
  logic [DSW-1:0]   dvs_mag;
  logic             neg_r;
  logic             neg_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             din1_zero;
  logic             last_step;
  logic [DDW-1:0]   din0_mag;
  logic [DSW-1:0]   din1_mag;
  logic [DSW:0]     rem_next;
  logic             q_bit;
  logic [DDW-1:0]   q_mag;
  logic [DSW-1:0]   r_mag;
  logic [QW-1:0]    q_fin;
  logic [DSW-1:0]   r_fin;
  logic             ov_fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign din1_zero = (din1 == '0);
  assign last_step = (state == CALC) && (cnt == CNT_W'(1));

  assign din0_mag = din0[DDW-1] ? (~din0 + DDW'(1)) : din0;
  assign din1_mag = din1[DSW-1] ? (~din1 + DSW'(1)) : din1;

  fir_hls_div_step #(.DSW(DSW)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd[DDW-1]),
    .dvs     (dvs_mag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // The dividend register doubles as the quotient register: bits leave at the
  // top while quotient bits enter at the bottom.
  assign q_mag = {dvd[DDW-2:0], q_bit};
  assign r_mag = rem_next[DSW-1:0];

  always_comb begin
    ov_fin = 1'b0;
    q_fin  = q_mag[QW-1:0];
    if (neg_q) begin
      if (q_mag > NEG_LIM) begin
        q_fin  = QMIN;
        ov_fin = 1'b1;
      end else begin
        q_fin = ~q_mag[QW-1:0] + QW'(1);
      end
    end else if (q_mag > POS_LIM) begin
      q_fin  = QMAX;
      ov_fin = 1'b1;
    end
    r_fin = neg_r ? (~r_mag + DSW'(1)) : r_mag;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = din1_zero ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dvd         <= '0;
      prem        <= '0;
      dvs_mag     <= '0;
      neg_r       <= 1'b0;
      neg_q       <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      dvd         <= din0_mag;
      dvs_mag     <= din1_mag;
      neg_r       <= din0[DDW-1];
      neg_q       <= din0[DDW-1] ^ din1[DSW-1];
      prem        <= '0;
      cnt         <= CNT_W'(DDW);
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      if (din1_zero) begin
        quotient    <= din0[DDW-1] ? QMIN : QMAX;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      prem <= rem_next;
      dvd  <= {dvd[DDW-2:0], q_bit};
      cnt  <= cnt - CNT_W'(1);
      if (last_step) begin
        quotient  <= q_fin;
        remainder <= r_fin;
        overflow  <= ov_fin;
      end
    end
  end

endmodule

// File: tb/tb_fir_hls_sdiv_31s_15s_seq.sv
// Self-checking bench for the sequential signed divider: directed, random,
// backpressure, back-to-back and mid-operation reset scenarios.
module tb_fir_hls_sdiv_31s_15s_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] din0 = '0;
  logic [14:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [14:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Packed result: {div_by_zero, overflow, remainder[14:0], quotient[15:0]}
  logic [32:0] exp_q[$];

  always #5 ap_clk = ~ap_clk;

  fir_hls_sdiv_31s_15s_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Reference: integer division truncating toward zero, then saturation.
  function automatic logic [32:0] model(input logic signed [30:0] a, input logic signed [14:0] b);
    longint la, lb, qq, rr;
    logic [15:0] q;
    logic [14:0] r;
    logic ov, dz;
    la = a;
    lb = b;
    ov = 1'b0;
    if (lb == 0) begin
      dz = 1'b1;
      r  = '0;
      q  = (la >= 0) ? 16'h7fff : 16'h8000;
    end else begin
      dz = 1'b0;
      qq = la / lb;
      rr = la % lb;
      r  = rr[14:0];
      if (qq > 32767) begin
        q = 16'h7fff; ov = 1'b1;
      end else if (qq < -32768) begin
        q = 16'h8000; ov = 1'b1;
      end else begin
        q = qq[15:0];
      end
    end
    return {dz, ov, r, q};
  endfunction

  function automatic int exp_lat(input logic [14:0] b);
    return (b == '0) ? 1 : 32;
  endfunction

  // Driver: offer one operand pair, count edges from the accept edge to out_valid.
  task automatic run_op(input logic [30:0] a, input logic [14:0] b, input bit release_out,
                        output logic [32:0] got, output int lat);
    int guard;
    @(negedge ap_clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge ap_clk);
      guard++;
    end
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    exp_q.push_back(model(a, b));
    @(posedge ap_clk);
    lat = 1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
    got = {div_by_zero, overflow, remainder, quotient};
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_during: got %b expected 1", in_ready); else n_pass++;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (quotient !== 16'h0) $display("FAIL reset_quotient: got %h expected 0", quotient); else n_pass++;
    n_checks++; if (remainder !== 15'h0) $display("FAIL reset_remainder: got %h expected 0", remainder); else n_pass++;
    n_checks++; if ({div_by_zero, overflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {div_by_zero, overflow}); else n_pass++;
  endtask

  task automatic test_directed;
    logic [30:0] ta[7];
    logic [14:0] tb[7];
    logic [32:0] got, exp;
    int lat;
    ta = '{31'd3962745, 31'd1000, -31'sd1000, 31'h40000000, -31'sd32768, -31'sd5, 31'd0};
    tb = '{15'd321, -15'sd7, 15'd7, -15'sd1, 15'd1, 15'd0, 15'd77};
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], 1'b1, got, lat);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL directed_%0d_result: got %h expected %h", i, got, exp); else n_pass++;
      n_checks++;
      if (lat != exp_lat(tb[i])) $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, exp_lat(tb[i])); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [30:0] a;
    logic [14:0] b;
    logic [32:0] got, exp;
    int lat, t;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = 31'($urandom);
      end else begin
        t = int'($urandom_range(0, 2000000)) - 1000000;
        a = t[30:0];
      end
      case ($urandom_range(0, 3))
        0: b = 15'($urandom);
        1: begin t = int'($urandom_range(1, 40)); b = ($urandom_range(0, 1) != 0) ? t[14:0] : -t[14:0]; end
        2: b = 15'h4000;
        default: b = 15'($urandom_range(100, 16383));
      endcase
      run_op(a, b, 1'b1, got, lat);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL random_%0d_result a=%h b=%h: got %h expected %h", i, a, b, got, exp); else n_pass++;
      n_checks++;
      if (lat != exp_lat(b)) $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, exp_lat(b)); else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [32:0] got, exp, now;
    int lat;
    run_op(-31'sd123456, 15'd100, 1'b0, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL bp_result: got %h expected %h", got, exp); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      din0 = 31'd999;
      din1 = 15'd3;
      @(posedge ap_clk);
      @(negedge ap_clk);
      now = {div_by_zero, overflow, remainder, quotient};
      n_checks++; if (now !== exp || out_valid !== 1'b1) $display("FAIL bp_hold_%0d: got %h/%b expected %h/1", c, now, out_valid, exp); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b expected 0", c, in_ready); else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", in_ready, out_valid); else n_pass++;
    run_op(31'd50000, -15'sd9, 1'b1, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL bp_next_result: got %h expected %h", got, exp); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp, got;
    int seen[$];
    exp = model(31'd7777777, 15'd1234);
    out_ready = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b1;
    din0 = 31'd7777777;
    din1 = 15'd1234;
    for (int c = 0; c < 200 && seen.size() < 2; c++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (out_valid) begin
        seen.push_back(c);
        got = {div_by_zero, overflow, remainder, quotient};
        n_checks++; if (got !== exp) $display("FAIL b2b_result_%0d: got %h expected %h", seen.size(), got, exp); else n_pass++;
        if (seen.size() == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (seen.size() != 2) $display("FAIL b2b_count: got %0d results expected 2", seen.size());
    else if (seen[1] - seen[0] != 33) $display("FAIL b2b_period: got %0d expected 33", seen[1] - seen[0]);
    else n_pass++;
    @(posedge ap_clk);
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [32:0] got, exp;
    int lat;
    @(negedge ap_clk);
    in_valid = 1'b1;
    din0 = 31'd5000;
    din1 = 15'd3;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (14) @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if ({quotient, remainder} !== 31'h0) $display("FAIL rst_mid_outputs: got %h expected 0", {quotient, remainder}); else n_pass++;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (40) begin
      @(negedge ap_clk);
      if (out_valid) break;
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_no_result: got %b expected 0", out_valid); else n_pass++;
    run_op(31'd100, 15'd9, 1'b1, got, lat);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL rst_mid_after: got %h expected %h", got, exp); else n_pass++;
    n_checks++; if (lat != 32) $display("FAIL rst_mid_after_latency: got %0d expected 32", lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
